// File: rtl/truth_table_sweeper_if.sv
// Harness-side bundle for one truth-table sweeper: control, expected code,
// drive/observe of the function under test and the captured result.
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic [2:0] dut_in;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic [7:0] table_code;  // 'table' is a reserved word in SystemVerilog
  logic       match;

  modport master (
    output start, abort, expected, dut_out,
    input  dut_in, busy, done, table_code, match
  );

  modport slave (
    input  start, abort, expected, dut_out,
    output dut_in, busy, done, table_code, match
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a 3-input function through all 8 input vectors, waits a settle interval
// on each, captures the 8-bit truth-table code and compares it with a latched expectation.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.slave bus
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CODE_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    vec_q, vec_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                match_q, match_d;
  logic [CODE_W-1:0]   exp_q, exp_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      code_q  <= '0;
      match_q <= 1'b0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      code_q  <= code_d;
      match_q <= match_d;
      exp_q   <= exp_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    code_d  = code_q;
    match_d = match_q;
    exp_d   = exp_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          idx_d   = '0;
          cnt_d   = '0;
          vec_d   = '0;
          code_d  = '0;
          match_d = 1'b0;
          exp_d   = bus.expected;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        // Input 000 lands in the MSB, input 111 in the LSB
        code_d[~idx_q] = bus.dut_out;
        if (idx_q == IDX_LAST) begin
          done_d  = 1'b1;
          match_d = (code_d == exp_q);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          vec_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over every in-sweep transition
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      vec_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      code_d  = '0;
      match_d = 1'b0;
    end
  end

  assign bus.dut_in     = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.table_code = code_q;
  assign bus.match      = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 4 and settle 1) share stimulus
// and are checked each cycle against a time-based model of the sweep.
module tb_truth_table_sweeper;

  localparam int unsigned S_A = 4;
  localparam int unsigned S_B = 1;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic [7:0] func;

  int checks;
  int errors;
  bit armed;

  truth_table_sweeper_if bus_a ();
  truth_table_sweeper_if bus_b ();

  assign bus_a.start    = start;
  assign bus_a.abort    = abort;
  assign bus_a.expected = expected;
  assign bus_a.dut_out  = func[~bus_a.dut_in];
  assign bus_b.start    = start;
  assign bus_b.abort    = abort;
  assign bus_b.expected = expected;
  assign bus_b.dut_out  = func[~bus_b.dut_in];

  truth_table_sweeper #(.SETTLE_CYCLES(S_A), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  truth_table_sweeper #(.SETTLE_CYCLES(S_B), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a sweep is described by cycles elapsed since the accepting edge
  bit         m_act   [2];
  int         m_t     [2];
  logic [7:0] m_exp   [2];
  logic [7:0] m_code  [2];
  logic [2:0] m_din   [2];
  logic       m_busy  [2];
  logic       m_done  [2];
  logic [7:0] m_tbl   [2];
  logic       m_match [2];

  function automatic int period(input int k);
    return (k == 0) ? int'(S_A) + 1 : int'(S_B) + 1;
  endfunction

  function automatic void model_eval(input int k);
    int p;
    int len;
    int v;
    p   = period(k);
    len = 8 * p;
    v   = m_t[k] / p;
    m_busy[k] = 1'b1;
    m_din[k]  = 3'((v > 7) ? 7 : v);
    m_tbl[k]  = 8'h00;
    for (int i = 0; i < 8; i++)
      if ((i + 1) * p <= m_t[k]) m_tbl[k][7-i] = m_code[k][7-i];
    m_done[k]  = (m_t[k] == len);
    m_match[k] = (m_t[k] == len) && (m_code[k] == m_exp[k]);
  endfunction

  function automatic void model_clear(input int k);
    m_act[k]   = 1'b0;
    m_din[k]   = 3'd0;
    m_busy[k]  = 1'b0;
    m_done[k]  = 1'b0;
    m_tbl[k]   = 8'h00;
    m_match[k] = 1'b0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        model_clear(k);
      end else if (m_act[k]) begin
        if (abort) begin
          model_clear(k);
        end else begin
          m_t[k] = m_t[k] + 1;
          if (m_t[k] > 8 * period(k)) begin
            m_act[k]  = 1'b0;
            m_busy[k] = 1'b0;
            m_done[k] = 1'b0;
          end else begin
            model_eval(k);
          end
        end
      end else if (start && !abort) begin
        m_act[k]  = 1'b1;
        m_t[k]    = 0;
        m_exp[k]  = expected;
        m_code[k] = func;
        model_eval(k);
      end
    end
    if (rst) armed = 1'b1;
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("a_dut_in", 32'(bus_a.dut_in), 32'(m_din[0]));
      chk("a_busy", 32'(bus_a.busy), 32'(m_busy[0]));
      chk("a_done", 32'(bus_a.done), 32'(m_done[0]));
      chk("a_table", 32'(bus_a.table_code), 32'(m_tbl[0]));
      chk("a_match", 32'(bus_a.match), 32'(m_match[0]));
      chk("b_dut_in", 32'(bus_b.dut_in), 32'(m_din[1]));
      chk("b_busy", 32'(bus_b.busy), 32'(m_busy[1]));
      chk("b_done", 32'(bus_b.done), 32'(m_done[1]));
      chk("b_table", 32'(bus_b.table_code), 32'(m_tbl[1]));
      chk("b_match", 32'(bus_b.match), 32'(m_match[1]));
    end
  end

  // One full sweep with stray start pulses; returns the done cycle of each instance
  task automatic run_sweep(input logic [7:0] f, input logic [7:0] e,
                           output int ca, output int cb);
    func     = f;
    expected = e;
    start    = 1'b1;
    @(negedge clk);
    ca = -1;
    cb = -1;
    for (int c = 1; c <= 80; c++) begin
      if (c == 1) chk("lit_table_cleared", 32'(bus_a.table_code), 32'h00);
      if (c == 6) chk("lit_a_vec1", 32'(bus_a.dut_in), 32'd1);
      if (bus_a.done === 1'b1 && ca < 0) ca = c;
      if (bus_b.done === 1'b1 && cb < 0) cb = c;
      if (ca > 0 && cb > 0 && c > ca) break;
      start = (c == 3 || c == 10);
      expected = (c == 20) ? ~e : expected;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  int ca, cb, hits;

  initial begin
    checks = 0;
    errors = 0;
    armed  = 1'b0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; expected = 8'h00; func = 8'h00;
    repeat (3) @(negedge clk);
    chk("lit_reset_busy", 32'(bus_a.busy), 32'd0);
    chk("lit_reset_table", 32'(bus_a.table_code), 32'h00);
    chk("lit_reset_dut_in", 32'(bus_a.dut_in), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_sweep(8'h9B, 8'h9B, ca, cb);
    chk("lit_done_cycle_a", 32'(ca), 32'd41);
    chk("lit_done_cycle_b", 32'(cb), 32'd17);
    chk("lit_table_9b", 32'(bus_a.table_code), 32'h9B);
    chk("lit_match_1", 32'(bus_a.match), 32'd1);
    chk("lit_busy_after", 32'(bus_a.busy), 32'd0);
    chk("lit_hold_vec7", 32'(bus_a.dut_in), 32'd7);

    run_sweep(8'h9B, 8'hD9, ca, cb);
    chk("lit_table_9b_2", 32'(bus_a.table_code), 32'h9B);
    chk("lit_match_0", 32'(bus_a.match), 32'd0);
    chk("lit_done_cycle_a2", 32'(ca), 32'd41);

    run_sweep(8'hFF, 8'hFF, ca, cb);
    chk("lit_b_table_ff", 32'(bus_b.table_code), 32'hFF);
    chk("lit_b_done_17", 32'(cb), 32'd17);

    // Abort during vector 3
    func = 8'h9B; expected = 8'h9B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hits = 0;
    for (int c = 0; c < 100 && bus_a.dut_in !== 3'd3; c++) @(negedge clk);
    chk("lit_reach_vec3", 32'(bus_a.dut_in), 32'd3);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("lit_abort_busy", 32'(bus_a.busy), 32'd0);
    chk("lit_abort_dut_in", 32'(bus_a.dut_in), 32'd0);
    chk("lit_abort_table", 32'(bus_a.table_code), 32'h00);
    chk("lit_abort_match", 32'(bus_a.match), 32'd0);
    for (int c = 0; c < 50; c++) begin
      if (bus_a.done === 1'b1) hits++;
      @(negedge clk);
    end
    chk("lit_abort_no_done", 32'(hits), 32'd0);
    run_sweep(8'h9B, 8'h9B, ca, cb);
    chk("lit_after_abort_done", 32'(ca), 32'd41);
    chk("lit_after_abort_match", 32'(bus_a.match), 32'd1);

    // Reset mid-sweep, then reset together with start
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lit_rst_busy", 32'(bus_a.busy), 32'd0);
    chk("lit_rst_dut_in", 32'(bus_a.dut_in), 32'd0);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("lit_rst_start_busy", 32'(bus_a.busy), 32'd0);

    // start with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("lit_start_abort_busy", 32'(bus_a.busy), 32'd0);
    @(negedge clk);
    chk("lit_start_abort_busy2", 32'(bus_a.busy), 32'd0);

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 399) == 0);
      abort = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 5) == 0);
      if (!m_act[0] && !m_act[1]) func = 8'($urandom);
      expected = ($urandom_range(0, 1) == 0) ? func : 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; abort = 1'b0; start = 1'b0;
    repeat (60) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exercises one 3-input, 1-output combinational logic function under test (e.g. a synthesized 0x9B-style gate).
- Drives all 8 input combinations in ascending order and waits a settle interval after each.
- Samples the function output and assembles the 8-bit truth-table code, then compares it against an expected code.
- Sits between the test/characterisation harness and the gate netlist; one sweeper per function under test.

Parameters:
SETTLE_CYCLES, 4, cycles the input vector is held before sampling; legal range 1..255
CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  cancel a sweep in progress; return to IDLE
expected  input  8  expected truth-table code, sampled on the accepted start
dut_in  output  3  input vector to the function under test, {in1,in2,in3}
dut_out  input  1  output of the function under test
busy  output  1  high from the accepted start until done or abort
done  output  1  one-cycle pulse when the sweep completes
table  output  8  captured truth-table code
match  output  1  table == expected latched; valid from done until the next accepted start

Behaviour:
- Reset values: state IDLE, dut_in=3'b000, busy=0, done=0, table=8'h00, match=0, idx=0, cnt=0, latched expected=8'h00.
- Code convention: table[7-idx] = function output for input idx.
  - Input 3'b000 maps to the MSB; input 3'b111 maps to the LSB.
  - Example: a function true on 000, 011, 100, 110, 111 yields 8'h9B.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0 → idx<=0, dut_in<=000, cnt<=0, table<=0, match<=0, expected latched, busy<=1, go to SETTLE.
  - start=1 and abort=1 in the same cycle → start ignored, remain IDLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - table[7-idx] <= dut_out.
  - If idx==7, go to DONE.
  - Otherwise idx<=idx+1, dut_in<=idx+1, cnt<=0, go to SETTLE.
- DONE:
  - done=1 for exactly this cycle.
  - match <= (table_final == expected), using the table value that includes the last sample.
  - busy<=0; next state IDLE.
- Latency:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done is high in cycle 8*(SETTLE_CYCLES+1)+1 after the start-accepting edge (41 for default).
- dut_in changes only on the SAMPLE→SETTLE transition, on start, on abort or on reset; it is stable throughout every SETTLE window.
- start while busy is ignored; the sweep is not restarted.
- abort while busy, in any non-IDLE state including DONE:
  - Next state IDLE; busy<=0; dut_in<=000; table<=0; match<=0.
  - No done pulse.
  - abort takes priority over the SETTLE/SAMPLE transitions in the same cycle.
- rst overrides everything, including mid-sweep; all outputs return to their reset values on the next edge.
- After done: table, match and dut_in=3'b111 hold until the next accepted start, abort or reset.
- Back-to-back operation: start may be accepted in the IDLE cycle immediately after DONE.
- expected changing mid-sweep has no effect; the value latched at start is used.

Test Plan:
- Sweep, default parameters, dut_out modelled as the 0x9B function, expected=8'h9B, start for 1 cycle → dut_in steps 0..7, each held 5 cycles; done pulses at cycle 41; table=8'h9B, match=1; busy low after done.
- Same function, expected=8'hD9 (bit-reversed) → table=8'h9B, match=0, done still pulses once.
- SETTLE_CYCLES=1, dut_out tied 1 → table=8'hFF; done at cycle 17; start pulses during the sweep are ignored; dut_in never skips a value.
- abort asserted during the 4th vector (dut_in=3'b011) → next cycle IDLE; busy=0, dut_in=000, table=00, match=0; no done. A fresh start then completes normally.
- rst asserted mid-sweep, and rst together with start → all outputs at reset values the following cycle; no done pulse.
- start and abort together in IDLE → remains IDLE, busy stays 0. start in the cycle after done → a second sweep runs, and table is cleared to 00 at its start.
